idli_utx_m: RTL and testbench

UART transmitter for the idli core: the transmit-side counterpart of the core's UART receiver. It accepts a 16-bit word from EX as four 4-bit slices, aligned to the core's 4-GCK sync counter. It serialises the word onto the top-level `uart_tx` pin as two 8N1 frames, low byte first. A one-word holding buffer lets EX hand over the next word while the current one is on the line; EX is stalled only when both the shifter and the buffer are occupied.

---
 rtl/idli_utx_m.sv | 181 ++++++++++++++++++
 tb/tb_idli_utx_m.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/idli_utx_m.sv
// idli_utx_m: UART transmitter. It takes a 16-bit word from EX as four ctr-aligned slices and sends it as two frames, low byte first.
// Define IDLI_UTX_PARITY_EN to add an even-parity bit to each byte frame.
module idli_utx_m #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_utx_gck,
  input  logic       i_utx_rst_n,
  input  logic [1:0] i_utx_ctr,
  input  logic       i_utx_vld,
  input  logic [3:0] i_utx_data,
  output logic       o_utx_stall,
  output logic       o_utx_tx
);

  // state   | meaning
  // S_IDLE  | line high, waiting for a committed or buffered word
  // S_START | start bit (0)
  // S_DATA  | 8 data bits, LSB first, idx selects the bit
  // S_PAR   | even parity bit (parity build only)
  // S_STOP  | stop bit (1); then byte 1, the buffered word, or idle
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef IDLI_UTX_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_t;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_TC = CW'(CLKS_PER_BIT - 1);

  state_t        state, state_n;
  logic [CW-1:0] baud, baud_n;
  logic [2:0]    idx, idx_n;
  logic          byte_hi, byte_hi_n;
  logic [15:0]   sh_word, sh_word_n;
  logic [15:0]   buf_word, buf_word_n;
  logic          buf_vld, buf_vld_n;
  logic          cap, cap_n;
  logic [11:0]   cap_word;
  logic          tx_n;

  logic          accept, capturing, commit, direct, commit_buf, drain, tick;
  logic [15:0]   full_word;
  logic [7:0]    cur_byte;

  always_comb begin
    accept     = (i_utx_ctr == 2'd0) && i_utx_vld && !o_utx_stall;
    capturing  = accept || (cap && (i_utx_ctr != 2'd0));
    commit     = capturing && (i_utx_ctr == 2'd3);
    full_word  = {i_utx_data, cap_word};
    direct     = commit && (state == S_IDLE) && !buf_vld;
    commit_buf = commit && !direct;
    tick       = (baud == BAUD_TC);

    cap_n = cap;
    if (i_utx_ctr == 2'd0)      cap_n = accept;
    else if (i_utx_ctr == 2'd3) cap_n = 1'b0;

    state_n   = state;
    baud_n    = baud + CW'(1);
    idx_n     = idx;
    byte_hi_n = byte_hi;
    sh_word_n = sh_word;
    drain     = 1'b0;

    case (state)
      S_IDLE: begin
        baud_n = '0;
        if (direct) begin
          state_n   = S_START;
          sh_word_n = full_word;
          byte_hi_n = 1'b0;
        end else if (buf_vld) begin
          state_n   = S_START;
          sh_word_n = buf_word;
          byte_hi_n = 1'b0;
          drain     = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          baud_n  = '0;
          idx_n   = 3'd0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          baud_n = '0;
          if (idx == 3'd7) begin
`ifdef IDLI_UTX_PARITY_EN
            state_n = S_PAR;
`else
            state_n = S_STOP;
`endif
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
`ifdef IDLI_UTX_PARITY_EN
      S_PAR: begin
        if (tick) begin
          baud_n  = '0;
          state_n = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          baud_n = '0;
          if (!byte_hi) begin
            byte_hi_n = 1'b1;
            state_n   = S_START;
          end else if (buf_vld) begin
            state_n   = S_START;
            sh_word_n = buf_word;
            byte_hi_n = 1'b0;
            drain     = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A commit landing on the same edge as a drain refills the buffer.
    buf_vld_n  = (buf_vld && !drain) || commit_buf;
    buf_word_n = commit_buf ? full_word : buf_word;

    cur_byte = byte_hi_n ? sh_word_n[15:8] : sh_word_n[7:0];
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = cur_byte[idx_n];
`ifdef IDLI_UTX_PARITY_EN
      S_PAR:   tx_n = ^cur_byte;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge i_utx_gck) begin
    if (!i_utx_rst_n) begin
      state       <= S_IDLE;
      baud        <= '0;
      idx         <= '0;
      byte_hi     <= 1'b0;
      sh_word     <= '0;
      buf_word    <= '0;
      buf_vld     <= 1'b0;
      cap         <= 1'b0;
      cap_word    <= '0;
      o_utx_stall <= 1'b0;
      o_utx_tx    <= 1'b1;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      idx      <= idx_n;
      byte_hi  <= byte_hi_n;
      sh_word  <= sh_word_n;
      buf_word <= buf_word_n;
      buf_vld  <= buf_vld_n;
      cap      <= cap_n;
      o_utx_tx <= tx_n;
      if (i_utx_ctr == 2'd3) o_utx_stall <= buf_vld_n;
      if (capturing) begin
        case (i_utx_ctr)
          2'd0:    cap_word[3:0]  <= i_utx_data;
          2'd1:    cap_word[7:4]  <= i_utx_data;
          2'd2:    cap_word[11:8] <= i_utx_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_idli_utx_m.sv
// tb_idli_utx_m: directed bench for idli_utx_m with CLKS_PER_BIT=4. A receiver decodes the line.
// The parity case is built only when IDLI_UTX_PARITY_EN is defined.
module tb_idli_utx_m;

  localparam int N = 4;
`ifdef IDLI_UTX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld = 1'b0;
  logic [1:0] ctr = 2'd0;
  logic [3:0] data = 4'd0;
  logic       stall, tx;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] rx_byte[$];
  int         rx_start[$];
  logic       rx_ok[$];
  logic       rx_par[$];

  idli_utx_m #(.CLKS_PER_BIT(N)) dut (
    .i_utx_gck   (clk),
    .i_utx_rst_n (rst_n),
    .i_utx_ctr   (ctr),
    .i_utx_vld   (vld),
    .i_utx_data  (data),
    .o_utx_stall (stall),
    .o_utx_tx    (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line receiver, sampling at bit centres on the falling clock edge.
  initial begin : mon
    int ph, b, st;
    logic [7:0] sh;
    logic okb, pb, busy;
    busy = 1'b0; ph = 0; b = 0; st = 0; sh = '0; okb = 1'b0; pb = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0;
      end else if (!busy) begin
        if (tx == 1'b0) begin
          busy = 1'b1; ph = 0; st = cyc; okb = 1'b1; sh = '0; pb = 1'b0;
        end
      end else begin
        ph++;
        if (ph % N == N / 2) begin
          b = ph / N;
          if (b == 0) begin
            if (tx !== 1'b0) okb = 1'b0;
          end else if (b <= 8) begin
            sh[b-1] = tx;
          end else if (b == FL - 1) begin
            if (tx !== 1'b1) okb = 1'b0;
            rx_byte.push_back(sh);
            rx_start.push_back(st);
            rx_ok.push_back(okb);
            rx_par.push_back(pb);
            busy = 1'b0;
          end else begin
            pb = tx;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc_step(input logic v, input logic [3:0] d);
    vld  = v;
    data = d;
    @(posedge clk);
    #1;
    ctr = ctr + 2'd1;
  endtask

  task automatic send_window(input logic v, input logic [15:0] w);
    while (ctr != 2'd0) cyc_step(1'b0, 4'd0);
    for (int i = 0; i < 4; i++) cyc_step(v, w[4*i +: 4]);
    vld = 1'b0;
  endtask

  task automatic idle_window();
    send_window(1'b0, 16'h0000);
  endtask

  task automatic clear_rx();
    rx_byte.delete();
    rx_start.delete();
    rx_ok.delete();
    rx_par.delete();
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int w;
    w = 0;
    while (rx_byte.size() < n && w < 80) begin
      idle_window();
      w++;
    end
    idle_window();
    idle_window();
    chk($sformatf("%s_cnt", tag), rx_byte.size(), n);
  endtask

  task automatic chk_frames(input string tag, input int n, input logic [47:0] eb);
    for (int i = 0; i < n; i++) begin
      logic [7:0] e;
      e = eb[8*i +: 8];
      if (i < rx_byte.size()) begin
        chk($sformatf("%s_byte%0d", tag, i), rx_byte[i], e);
        chk($sformatf("%s_frm%0d", tag, i), rx_ok[i], 1);
        if (i > 0) chk($sformatf("%s_gap%0d", tag, i), rx_start[i] - rx_start[i-1], FL * N);
      end else begin
        chk($sformatf("%s_present%0d", tag, i), rx_byte.size(), i + 1);
      end
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t0;
    logic [12:0] exp_line;
    int w;

    // Reset state
    idle_window();
    idle_window();
    chk("rst_tx", tx, 1);
    chk("rst_stall", stall, 0);
    rst_n = 1'b1;
    idle_window();

    // Single word 0xA55A: start 0, bit0 0, bit1 1, bit2 0, each held N cycles
    clear_rx();
    send_window(1'b1, 16'hA55A);
    t0 = cyc;
    chk("t1_fall", tx, 0);
    chk("t1_stall", stall, 0);
    exp_line = 13'b0_1111_0000_0000;
    for (int k = 1; k <= 12; k++) begin
      cyc_step(1'b0, 4'd0);
      chk($sformatf("t1_line%0d", k), tx, exp_line[k]);
    end
    wait_bytes(2, "t1");
    chk_frames("t1", 2, {32'h0, 8'hA5, 8'h5A});
    if (rx_start.size() > 0) chk("t1_t0", rx_start[0], t0);

    // Back-to-back burst
    clear_rx();
    send_window(1'b1, 16'h1234);
    chk("t2_stall_w1", stall, 0);
    send_window(1'b1, 16'h5678);
    chk("t2_stall_w2", stall, 1);
    send_window(1'b1, 16'h9ABC);
    chk("t2_stall_w3", stall, 1);
    w = 0;
    while (stall && w < 40) begin
      idle_window();
      w++;
    end
    chk("t2_stall_drop", stall, 0);
    send_window(1'b1, 16'h9ABC);
    chk("t2_stall_retry", stall, 1);
    wait_bytes(6, "t2");
    chk_frames("t2", 6, {8'h9A, 8'hBC, 8'h56, 8'h78, 8'h12, 8'h34});

    // Misaligned valid: vld first seen at ctr==2
    clear_rx();
    cyc_step(1'b0, 4'h0);
    cyc_step(1'b0, 4'h0);
    cyc_step(1'b1, 4'hF);
    cyc_step(1'b1, 4'hF);
    chk("t3_mis_tx", tx, 1);
    chk("t3_mis_stall", stall, 0);
    send_window(1'b1, 16'h0001);
    chk("t3_fall", tx, 0);
    wait_bytes(2, "t3");
    chk_frames("t3", 2, {32'h0, 8'h00, 8'h01});

    // Reset during bit 3 of byte 1 (0xC3 bit3 = 0), with a second word buffered
    clear_rx();
    send_window(1'b1, 16'hC3C3);
    t0 = cyc;
    send_window(1'b1, 16'h2222);
    chk("t4_stall_pre", stall, 1);
    while (cyc < t0 + FL * N + 4 * N + 1) cyc_step(1'b0, 4'd0);
    chk("t4_midbit", tx, 0);
    rst_n = 1'b0;
    cyc_step(1'b0, 4'd0);
    chk("t4_rst_tx", tx, 1);
    chk("t4_rst_stall", stall, 0);
    while (ctr != 2'd0) cyc_step(1'b0, 4'd0);
    rst_n = 1'b1;
    clear_rx();
    send_window(1'b1, 16'h00FF);
    chk("t4_fall", tx, 0);
    wait_bytes(2, "t4");
    chk_frames("t4", 2, {32'h0, 8'h00, 8'hFF});

`ifdef IDLI_UTX_PARITY_EN
    // Parity: 0x07 -> parity 1, 0x03 -> parity 0
    clear_rx();
    send_window(1'b1, 16'h0307);
    wait_bytes(2, "t5");
    chk_frames("t5", 2, {32'h0, 8'h03, 8'h07});
    if (rx_par.size() >= 2) begin
      chk("t5_par0", rx_par[0], 1);
      chk("t5_par1", rx_par[1], 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
